// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - address map, CTRL bit layout and status update rules for the KEY/SW device
package io_map_pkg;

  localparam logic [31:0] IO_ADDR_KDATA = 32'hF000_0010;
  localparam logic [31:0] IO_ADDR_KCTRL = 32'hF000_0110;
  localparam logic [31:0] IO_ADDR_SDATA = 32'hF000_0014;
  localparam logic [31:0] IO_ADDR_SCTRL = 32'hF000_0114;

  localparam int CTRL_READY   = 0;
  localparam int CTRL_OVERRUN = 2;
  localparam int CTRL_IE      = 4;

  localparam bit KEY_ACTIVE_LOW = 1'b1;

  typedef struct packed {
    logic ie;
    logic overrun;
    logic ready;
  } ctrl_t;

  // A new stable value always wins: it re-arms ready and its overrun set beats a clearing write.
  function automatic ctrl_t ctrl_next(input ctrl_t cur, input logic changed, input logic data_rd,
                                      input logic ctrl_wr, input logic wr_overrun, input logic wr_ie);
    ctrl_t nxt;
    nxt = cur;
    if (data_rd) nxt.ready = 1'b0;
    if (ctrl_wr) begin
      nxt.ie = wr_ie;
      if (!wr_overrun) nxt.overrun = 1'b0;
    end
    if (changed) begin
      if (cur.ready && !data_rd) nxt.overrun = 1'b1;
      nxt.ready = 1'b1;
    end
    return nxt;
  endfunction

  function automatic logic [4:0] ctrl_word(input ctrl_t c);
    logic [4:0] w;
    w = '0;
    w[CTRL_READY]   = c.ready;
    w[CTRL_OVERRUN] = c.overrun;
    w[CTRL_IE]      = c.ie;
    return w;
  endfunction

endpackage

// File: rtl/io_debouncer.sv
// rtl/io_debouncer.sv - two-flop synchronizer plus vector-wide debounce counter
module io_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             changed_o
);

  localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q, sync_q, stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             differs, accept;

  always_comb begin
    differs  = (sync_q != stable_q);
    accept   = differs && (cnt_q == CNT_LAST);
    stable_d = stable_q;
    cnt_d    = '0;
    if (accept) begin
      stable_d = sync_q;
    end else if (differs) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Pulses in the cycle whose closing edge loads the new stable value.
  assign changed_o = accept;
  assign stable_o  = stable_q;

endmodule

// File: rtl/key_sw_io_device.sv
// rtl/key_sw_io_device.sv - memory-mapped KEY/SW input device with sticky status and irq
module key_sw_io_device
  import io_map_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter int               DEBOUNCE_CYCLES = 100000,
  parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(IO_ADDR_KDATA),
  parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(IO_ADDR_KCTRL),
  parameter logic [DBITS-1:0] ADDR_SDATA      = DBITS'(IO_ADDR_SDATA),
  parameter logic [DBITS-1:0] ADDR_SCTRL      = DBITS'(IO_ADDR_SCTRL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic             wrEn,
  input  logic             rdEn,
  input  logic [DBITS-1:0] wrData,
  output logic [DBITS-1:0] rdData,
  output logic             hit,
  output logic             irq
);

  logic [3:0] key_pressed, key_stable;
  logic [9:0] sw_stable;
  logic       key_changed, sw_changed;
  logic       hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
  ctrl_t      kctrl_q, kctrl_d, sctrl_q, sctrl_d;
  logic       unused_wrdata;

  // Inverting ahead of the flops lets their zero reset value mean "released".
  assign key_pressed = KEY_ACTIVE_LOW ? ~KEY : KEY;

  io_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk       (clk),
    .reset     (reset),
    .raw_i     (key_pressed),
    .stable_o  (key_stable),
    .changed_o (key_changed)
  );

  io_debouncer #(.WIDTH(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk       (clk),
    .reset     (reset),
    .raw_i     (SW),
    .stable_o  (sw_stable),
    .changed_o (sw_changed)
  );

  assign hit_kdata = (addr == ADDR_KDATA);
  assign hit_kctrl = (addr == ADDR_KCTRL);
  assign hit_sdata = (addr == ADDR_SDATA);
  assign hit_sctrl = (addr == ADDR_SCTRL);
  assign hit       = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;

  always_comb begin
    kctrl_d = ctrl_next(kctrl_q, key_changed, rdEn & hit_kdata, wrEn & hit_kctrl,
                        wrData[CTRL_OVERRUN], wrData[CTRL_IE]);
    sctrl_d = ctrl_next(sctrl_q, sw_changed, rdEn & hit_sdata, wrEn & hit_sctrl,
                        wrData[CTRL_OVERRUN], wrData[CTRL_IE]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kctrl_q <= '0;
      sctrl_q <= '0;
    end else begin
      kctrl_q <= kctrl_d;
      sctrl_q <= sctrl_d;
    end
  end

  always_comb begin
    rdData = '0;
    if (hit_kdata)      rdData[3:0] = key_stable;
    else if (hit_kctrl) rdData[4:0] = ctrl_word(kctrl_q);
    else if (hit_sdata) rdData[9:0] = sw_stable;
    else if (hit_sctrl) rdData[4:0] = ctrl_word(sctrl_q);
  end

  assign irq = (kctrl_q.ready & kctrl_q.ie) | (sctrl_q.ready & sctrl_q.ie);

  assign unused_wrdata = ^{wrData[DBITS-1:5], wrData[3], wrData[1:0]};

endmodule

// File: tb/tb_key_sw_io_device.sv
// tb/tb_key_sw_io_device.sv - directed scoreboard bench for key_sw_io_device
module tb_key_sw_io_device;

  localparam logic [31:0] A_KDATA = 32'hF000_0010;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;
  localparam logic [31:0] A_SDATA = 32'hF000_0014;
  localparam logic [31:0] A_SCTRL = 32'hF000_0114;
  localparam logic [31:0] A_NONE  = 32'hF000_0018;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] addr;
  logic        wrEn, rdEn;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic        hit, irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  key_sw_io_device #(.DBITS(32), .DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .KEY    (KEY),
    .SW     (SW),
    .addr   (addr),
    .wrEn   (wrEn),
    .rdEn   (rdEn),
    .wrData (wrData),
    .rdData (rdData),
    .hit    (hit),
    .irq    (irq)
  );

  always #25 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] e);
    exp_t it;
    it.tag = tag;
    it.exp = e;
    sb_q.push_back(it);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t it;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h required=entry", obs);
      return;
    end
    it = sb_q.pop_front();
    assert (obs === it.exp) else begin
      errors++;
      $error("FAIL %s observed=%h required=%h", it.tag, obs, it.exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    push_exp(tag, e);
    addr = a;
    #1;
    pop_cmp(rdData);
  endtask

  task automatic irq_chk(input string tag, input logic e);
    push_exp(tag, {31'b0, e});
    #1;
    pop_cmp({31'b0, irq});
  endtask

  task automatic hit_chk(input string tag, input logic [31:0] a, input logic e);
    push_exp(tag, {31'b0, e});
    addr = a;
    #1;
    pop_cmp({31'b0, hit});
  endtask

  task automatic load(input logic [31:0] a);
    addr = a;
    rdEn = 1'b1;
    tick(1);
    rdEn = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    wrData = d;
    wrEn   = 1'b1;
    tick(1);
    wrEn   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; KEY = 4'hF; SW = '0; addr = '0;
    wrEn = 1'b0; rdEn = 1'b0; wrData = '0;
    tick(3);

    rd_chk("rst_kdata", A_KDATA, 32'h0);
    rd_chk("rst_kctrl", A_KCTRL, 32'h0);
    rd_chk("rst_sdata", A_SDATA, 32'h0);
    rd_chk("rst_sctrl", A_SCTRL, 32'h0);
    rd_chk("rst_nohit_rd", A_NONE, 32'h0);
    hit_chk("rst_nohit", A_NONE, 1'b0);
    hit_chk("hit_sctrl", A_SCTRL, 1'b1);
    irq_chk("rst_irq", 1'b0);

    // key 0 pressed across reset release
    KEY = 4'b1110;
    tick(1);
    reset = 1'b0;
    tick(5);
    rd_chk("key_edge5", A_KDATA, 32'h0);
    tick(1);
    rd_chk("key_edge6", A_KDATA, 32'h1);
    rd_chk("key_ready", A_KCTRL, 32'h1);
    load(A_KDATA);
    rd_chk("key_rd_clr", A_KCTRL, 32'h0);

    // two changes without a data read -> overrun
    KEY = 4'b1100;
    tick(6);
    rd_chk("key2_data", A_KDATA, 32'h3);
    rd_chk("key2_ctrl", A_KCTRL, 32'h1);
    KEY = 4'b1000;
    tick(6);
    rd_chk("key3_ovr", A_KCTRL, 32'h5);
    store(A_KCTRL, 32'h0);
    rd_chk("key3_ovr_clr", A_KCTRL, 32'h1);
    store(A_KDATA, 32'hF);
    rd_chk("kdata_ro", A_KDATA, 32'h7);
    load(A_KDATA);
    rd_chk("key3_rd_clr", A_KCTRL, 32'h0);

    // SW[3] bounce every 2 cycles, then settle high
    for (int i = 0; i < 10; i++) begin
      SW[3] = ~SW[3];
      tick(2);
      rd_chk("sw_bounce", A_SDATA, 32'h0);
    end
    SW[3] = 1'b1;
    tick(5);
    rd_chk("sw_edge5", A_SDATA, 32'h0);
    tick(1);
    rd_chk("sw_edge6", A_SDATA, 32'h8);
    rd_chk("sw_ready", A_SCTRL, 32'h1);
    load(A_SDATA);
    rd_chk("sw_rd_clr", A_SCTRL, 32'h0);

    // interrupt enable on switches
    store(A_SCTRL, 32'h10);
    rd_chk("sctrl_ie", A_SCTRL, 32'h10);
    irq_chk("irq_idle", 1'b0);
    SW = 10'h208;
    tick(5);
    irq_chk("irq_edge5", 1'b0);
    tick(1);
    irq_chk("irq_rise", 1'b1);
    rd_chk("sctrl_rdy_ie", A_SCTRL, 32'h11);
    rd_chk("sw_data2", A_SDATA, 32'h208);
    addr = A_SDATA;
    rdEn = 1'b1;
    irq_chk("irq_before_rd", 1'b1);
    tick(1);
    rdEn = 1'b0;
    irq_chk("irq_drop", 1'b0);
    rd_chk("sctrl_after_rd", A_SCTRL, 32'h10);

    // stable change coincident with a data read
    KEY = 4'b0000;
    tick(6);
    rd_chk("key4_ctrl", A_KCTRL, 32'h1);
    KEY = 4'b1111;
    tick(5);
    load(A_KDATA);
    rd_chk("coinc_rd_ctrl", A_KCTRL, 32'h1);
    rd_chk("coinc_rd_data", A_KDATA, 32'h0);

    // stable change coincident with an overrun-clearing store
    KEY = 4'b1110;
    tick(5);
    store(A_KCTRL, 32'h0);
    rd_chk("coinc_wr_ctrl", A_KCTRL, 32'h5);
    rd_chk("coinc_wr_data", A_KDATA, 32'h1);

    // reset while a new switch value is 3 counts in
    SW = 10'h001;
    tick(5);
    reset = 1'b1;
    tick(1);
    rd_chk("mid_kdata", A_KDATA, 32'h0);
    rd_chk("mid_kctrl", A_KCTRL, 32'h0);
    rd_chk("mid_sdata", A_SDATA, 32'h0);
    rd_chk("mid_sctrl", A_SCTRL, 32'h0);
    irq_chk("mid_irq", 1'b0);
    reset = 1'b0;
    tick(5);
    rd_chk("post_sdata5", A_SDATA, 32'h0);
    rd_chk("post_kdata5", A_KDATA, 32'h0);
    tick(1);
    rd_chk("post_sdata6", A_SDATA, 32'h1);
    rd_chk("post_kdata6", A_KDATA, 32'h1);
    rd_chk("post_sctrl6", A_SCTRL, 32'h1);
    irq_chk("post_irq", 1'b0);

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
